// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if
//   Bundles the CPU load/store request/response channel and the memory
//   controller DAT channel of the load/store sequencer.
//   Modports:
//     slave  - the sequencer's view: takes CPU requests and DAT_ACK/DAT_DATA_O,
//              drives req_ready, rsp_*, DAT_ADDR/DAT_DATA_I/DAT_REN/DAT_WEN.
//     master - the environment's view (CPU pipeline + memory controller).
interface dmem_access_unit_if #(
  parameter int ADDR_W = 32
);
  // CPU request
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  // CPU response
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  // Memory controller DAT port
  logic [ADDR_W-1:0] DAT_ADDR;
  logic [31:0]       DAT_DATA_I;
  logic              DAT_REN;
  logic              DAT_WEN;
  logic              DAT_ACK;
  logic [31:0]       DAT_DATA_O;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  DAT_ACK, DAT_DATA_O,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output DAT_ADDR, DAT_DATA_I, DAT_REN, DAT_WEN
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output DAT_ACK, DAT_DATA_O,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  DAT_ADDR, DAT_DATA_I, DAT_REN, DAT_WEN
  );
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//   Load/store sequencer in front of the memory controller DAT port. Takes one
//   CPU request at a time, turns byte/half/word accesses into word-aligned
//   DAT_REN/DAT_WEN transactions (read-modify-write for sub-word stores) and
//   returns aligned, sign/zero-extended load data.
//   Controller handshake: strobe held until ACK, strobe dropped, then ACK must
//   be seen low (GAP state) before the unit goes idle or issues another strobe.
//   Ports:
//     clk, rst - clock, asynchronous active-high reset
//     bus      - dmem_access_unit_if.slave (CPU req/rsp + DAT port)
//   Optional build macro:
//     MEM_TIMEOUT_EN - abort a strobe that waits TIMEOUT_CYCLES cycles without
//                      ACK, returning rsp_err=1. Undefined: wait indefinitely.
module dmem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  dmem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_GAP} state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  // Only the low half of store data is needed after acceptance: word stores
  // load DAT_DATA_I straight from the request.
  logic [15:0]       wlo_q, wlo_d;
  logic              rmw_q, rmw_d;
  logic [31:0]       rdword_q, rdword_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [31:0]       wdat_q, wdat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              req_bad;
  logic              tmo_hit;

  // Byte/half lane selection with optional sign extension; words pass through.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the read word with the store data.
  function automatic logic [31:0] rmw_merge(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic [15:0] wd);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  assign req_bad = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt_q;

  // Cleared on every state change, so each strobe gets a full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    cnt_q <= '0;
    else if (state_d != state_q)                cnt_q <= '0;
    else if (state_q == S_RD || state_q == S_WR) cnt_q <= cnt_q + 1'b1;
  end

  // Fires in the last allowed strobe cycle, so the strobe is high for
  // exactly TIMEOUT_CYCLES cycles.
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    wlo_d       = wlo_q;
    rmw_d       = rmw_q;
    rdword_d    = rdword_q;
    ren_d       = ren_q;
    wen_d       = wen_q;
    wdat_d      = wdat_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          addr_d = bus.req_addr;
          size_d = bus.req_size;
          sgn_d  = bus.req_signed;
          wlo_d  = bus.req_wdata[15:0];
          if (req_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (!bus.req_we) begin
            state_d = S_RD;
            ren_d   = 1'b1;
            rmw_d   = 1'b0;
          end else if (bus.req_size == 2'b10) begin
            state_d = S_WR;
            wen_d   = 1'b1;
            wdat_d  = bus.req_wdata;
            rmw_d   = 1'b0;
          end else begin
            state_d = S_RD;
            ren_d   = 1'b1;
            rmw_d   = 1'b1;
          end
        end
      end
      S_RD: begin
        if (bus.DAT_ACK) begin
          ren_d    = 1'b0;
          rdword_d = bus.DAT_DATA_O;
          state_d  = S_GAP;
          // The read half of an RMW answers nothing; the write ACK does.
          if (!rmw_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = load_extract(bus.DAT_DATA_O, addr_q[1:0], size_q, sgn_q);
          end
        end else if (tmo_hit) begin
          ren_d       = 1'b0;
          rmw_d       = 1'b0;  // aborted RMW never writes
          state_d     = S_GAP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      S_WR: begin
        if (bus.DAT_ACK) begin
          wen_d       = 1'b0;
          state_d     = S_GAP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else if (tmo_hit) begin
          wen_d       = 1'b0;
          state_d     = S_GAP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      S_GAP: begin
        if (!bus.DAT_ACK) begin
          if (rmw_q) begin
            state_d = S_WR;
            wen_d   = 1'b1;
            wdat_d  = rmw_merge(rdword_q, addr_q[1:0], size_q, wlo_q);
            rmw_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered ready: open only in IDLE and never alongside a response.
    ready_d = (state_d == S_IDLE) && !rsp_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      addr_q      <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      wlo_q       <= '0;
      rmw_q       <= 1'b0;
      rdword_q    <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      wlo_q       <= wlo_d;
      rmw_q       <= rmw_d;
      rdword_q    <= rdword_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      wdat_q      <= wdat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.DAT_ADDR   = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.DAT_DATA_I = wdat_q;
  assign bus.DAT_REN    = ren_q;
  assign bus.DAT_WEN    = wen_q;

endmodule
